// File: rtl/hwpe_ctrl_job_seq_pkg.sv
// Shared types and constants for the HWPE control job sequencer.
package hwpe_ctrl_job_seq_pkg;

  localparam int unsigned JOB_SEQ_ADDR_WIDTH      = 32;
  localparam int unsigned JOB_SEQ_CNT_WIDTH       = 16;
  localparam int unsigned JOB_SEQ_TIMEOUT_DEFAULT = 1024;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    JS_IDLE   = 3'd0,
    JS_ISSUE  = 3'd1,
    JS_WAIT   = 3'd2,
    JS_NEXT   = 3'd3,
    JS_FINISH = 3'd4
  } job_seq_state_t;

  // Job descriptor as programmed in the control slave (default widths).
  typedef struct packed {
    logic [JOB_SEQ_CNT_WIDTH-1:0]  n_tiles;
    logic [JOB_SEQ_ADDR_WIDTH-1:0] base_addr;
    logic [JOB_SEQ_ADDR_WIDTH-1:0] stride;
  } ctrl_job_t;

endpackage

// File: rtl/hwpe_ctrl_job_seq_if.sv
// Tile request stream between the job sequencer and the streamer/engine.
interface hwpe_ctrl_job_seq_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [CNT_WIDTH-1:0]  req_idx;
  logic                  tile_done;

  modport master (
    output req_valid, req_addr, req_idx,
    input  req_ready, tile_done
  );

  modport slave (
    input  req_valid, req_addr, req_idx,
    output req_ready, tile_done
  );

endinterface

// File: rtl/hwpe_ctrl_job_seq_tile_cnt.sv
// Tile index / address counter: load to (0, base), step by (1, stride), clear to 0.
module hwpe_ctrl_tile_cnt #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  output logic [CNT_WIDTH-1:0]  idx_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [CNT_WIDTH-1:0]  idx_r;
  logic [ADDR_WIDTH-1:0] addr_r;

  // Index and address registers; address arithmetic wraps silently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_r  <= '0;
      addr_r <= '0;
    end else if (clear_i) begin
      idx_r  <= '0;
      addr_r <= '0;
    end else if (load_i) begin
      idx_r  <= '0;
      addr_r <= base_i;
    end else if (step_i) begin
      idx_r  <= idx_r + CNT_WIDTH'(1);
      addr_r <= addr_r + stride_i;
    end else begin
      idx_r  <= idx_r;
      addr_r <= addr_r;
    end
  end

  assign idx_o  = idx_r;
  assign addr_o = addr_r;

endmodule

// File: rtl/hwpe_ctrl_job_seq.sv
// Job sequencer: walks n_tiles tiles, one request per tile, with a WAIT watchdog.
module hwpe_ctrl_job_seq
  import hwpe_ctrl_job_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = JOB_SEQ_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH  = JOB_SEQ_CNT_WIDTH,
  parameter int unsigned TIMEOUT    = JOB_SEQ_TIMEOUT_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  n_tiles_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  hwpe_ctrl_job_seq_if.master   req,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  evt_o,
  output logic                  err_o
);

  // Watchdog holds 0..TIMEOUT-1.
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  job_seq_state_t        state_r;
  logic [CNT_WIDTH-1:0]  n_tiles_r;
  logic [ADDR_WIDTH-1:0] stride_r;
  logic [WD_W-1:0]       wdog_r;
  logic                  valid_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  evt_r;
  logic                  err_r;

  logic                  cnt_load_s;
  logic                  cnt_step_s;
  logic [CNT_WIDTH-1:0]  idx_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [CNT_WIDTH-1:0]  last_idx_s;
  logic                  wd_expired_s;

  assign last_idx_s   = n_tiles_r - CNT_WIDTH'(1);
  assign wd_expired_s = (TIMEOUT != 0) && (wdog_r == WD_W'(TIMEOUT - 1));

  // Counter control: load on an accepted start, step when leaving NEXT.
  always_comb begin
    cnt_load_s = 1'b0;
    cnt_step_s = 1'b0;
    if ((state_r == JS_IDLE) && start_i) begin
      cnt_load_s = 1'b1;
    end else if (state_r == JS_NEXT) begin
      cnt_step_s = 1'b1;
    end else begin
      cnt_step_s = 1'b0;
    end
  end

  hwpe_ctrl_tile_cnt #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) i_tile_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .load_i   (cnt_load_s),
    .step_i   (cnt_step_s),
    .base_i   (base_addr_i),
    .stride_i (stride_r),
    .idx_o    (idx_s),
    .addr_o   (addr_s)
  );

  // Sequencer FSM with watchdog; all outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= JS_IDLE;
      n_tiles_r <= '0;
      stride_r  <= '0;
      wdog_r    <= '0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      evt_r     <= 1'b0;
      err_r     <= 1'b0;
    end else if (clear_i) begin
      state_r   <= JS_IDLE;
      n_tiles_r <= '0;
      stride_r  <= '0;
      wdog_r    <= '0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      evt_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      evt_r  <= 1'b0;
      case (state_r)
        JS_IDLE: begin
          if (start_i) begin
            n_tiles_r <= n_tiles_i;
            stride_r  <= stride_i;
            err_r     <= 1'b0;
            busy_r    <= 1'b1;
            if (n_tiles_i == CNT_WIDTH'(0)) begin
              state_r <= JS_FINISH;
            end else begin
              state_r <= JS_ISSUE;
              valid_r <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        JS_ISSUE: begin
          // tile_done_i is deliberately ignored here, handshake cycle included.
          if (req.req_ready) begin
            valid_r <= 1'b0;
            wdog_r  <= '0;
            state_r <= JS_WAIT;
          end else begin
            valid_r <= 1'b1;
          end
        end
        JS_WAIT: begin
          // A completion on the last watchdog cycle still counts as success.
          if (req.tile_done) begin
            evt_r <= 1'b1;
            if (idx_s == last_idx_s) begin
              state_r <= JS_FINISH;
            end else begin
              state_r <= JS_NEXT;
            end
          end else if (wd_expired_s) begin
            err_r   <= 1'b1;
            state_r <= JS_FINISH;
          end else begin
            wdog_r <= wdog_r + WD_W'(1);
          end
        end
        JS_NEXT: begin
          valid_r <= 1'b1;
          state_r <= JS_ISSUE;
        end
        JS_FINISH: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= JS_IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= JS_IDLE;
        end
      endcase
    end
  end

  assign req.req_valid = valid_r;
  assign req.req_addr  = addr_s;
  assign req.req_idx   = idx_s;
  assign busy_o        = busy_r;
  assign done_o        = done_r;
  assign evt_o         = evt_r;
  assign err_o         = err_r;

endmodule
